led_toggle_bank: RTL and testbench

//  NUM_CH-channel push-switch to LED controller for board-level UI.
//  Per channel: 2-flop synchroniser, counter debouncer, edge detector, LED register.

---
 rtl/led_toggle_bank.sv | 98 +++++++++
 tb/tb_led_toggle_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/led_toggle_bank.sv
// ============================================================================
//  Module      : led_toggle_bank
//  Description : Multi-channel push-switch to LED controller. Each channel
//                synchronises, debounces and edge-detects its switch and
//                drives an LED in TOGGLE or FOLLOW mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_toggle_bank #(
  parameter int NUM_CH         = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter bit EDGE_SEL       = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NUM_CH-1:0] SW,
  input  logic [NUM_CH-1:0] MODE,
  input  logic              CLR,
  output logic [NUM_CH-1:0] LED,
  output logic [NUM_CH-1:0] SW_DB,
  output logic [NUM_CH-1:0] EVT
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic [CNT_W-1:0] cnt_q,   cnt_d;
      logic             sw_db_q, sw_db_d;
      logic             dly_q,   dly_d;
      logic             evt_q,   evt_d;
      logic             led_q,   led_d;
      logic             edge_term;

      always_comb begin
        sync1_d = SW[g];
        sync2_d = sync1_q;

        // Any cycle where the synchronised level agrees with SW_DB restarts the count.
        cnt_d   = '0;
        sw_db_d = sw_db_q;
        if (sync2_q != sw_db_q) begin
          if (cnt_q == CNT_LAST) begin
            sw_db_d = sync2_q;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        dly_d     = sw_db_q;
        edge_term = EDGE_SEL ? (sw_db_q & ~dly_q) : (~sw_db_q & dly_q);
        evt_d     = edge_term;

        // CLR wins over everything, so a coincident toggle event is dropped.
        led_d = led_q;
        if (CLR) begin
          led_d = 1'b0;
        end else if (MODE[g]) begin
          led_d = sw_db_q;
        end else if (edge_term) begin
          led_d = ~led_q;
        end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          cnt_q   <= '0;
          sw_db_q <= 1'b0;
          dly_q   <= 1'b0;
          evt_q   <= 1'b0;
          led_q   <= 1'b0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          cnt_q   <= cnt_d;
          sw_db_q <= sw_db_d;
          dly_q   <= dly_d;
          evt_q   <= evt_d;
          led_q   <= led_d;
        end
      end

      assign LED[g]   = led_q;
      assign SW_DB[g] = sw_db_q;
      assign EVT[g]   = evt_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_led_toggle_bank.sv
// ============================================================================
//  Module      : tb_led_toggle_bank
//  Description : Bench for led_toggle_bank; release- and press-edge variants
//                share stimulus and are compared to a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_toggle_bank;

  localparam int NUM_CH = 4;
  localparam int LIMIT  = 4;

  logic              CLK;
  logic              RST_N;
  logic [NUM_CH-1:0] SW;
  logic [NUM_CH-1:0] MODE;
  logic              CLR;
  logic [NUM_CH-1:0] led0, db0, evt0;
  logic [NUM_CH-1:0] led1, db1, evt1;

  led_toggle_bank #(.NUM_CH(NUM_CH), .DEBOUNCE_LIMIT(LIMIT), .EDGE_SEL(1'b0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .MODE(MODE), .CLR(CLR),
    .LED(led0), .SW_DB(db0), .EVT(evt0)
  );

  led_toggle_bank #(.NUM_CH(NUM_CH), .DEBOUNCE_LIMIT(LIMIT), .EDGE_SEL(1'b1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .MODE(MODE), .CLR(CLR),
    .LED(led1), .SW_DB(db1), .EVT(evt1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: level accepted after LIMIT consecutive differing samples.
  logic [NUM_CH-1:0] m_p1, m_p2, m_db, m_prev;
  logic [NUM_CH-1:0] m_evt [2];
  logic [NUM_CH-1:0] m_led [2];
  int                m_run [NUM_CH];

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_db = '0; m_prev = '0;
    for (int e = 0; e < 2; e++) begin
      m_evt[e] = '0;
      m_led[e] = '0;
    end
    for (int c = 0; c < NUM_CH; c++) m_run[c] = 0;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] new_db;
    logic              fall, rise, ev;
    new_db = m_db;
    for (int c = 0; c < NUM_CH; c++) begin
      fall = m_prev[c] && !m_db[c];
      rise = !m_prev[c] && m_db[c];
      for (int e = 0; e < 2; e++) begin
        ev = (e == 1) ? rise : fall;
        m_evt[e][c] = ev;
        if (CLR)          m_led[e][c] = 1'b0;
        else if (MODE[c]) m_led[e][c] = m_db[c];
        else if (ev)      m_led[e][c] = !m_led[e][c];
      end
      if (m_p2[c] != m_db[c]) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] >= LIMIT) begin
          new_db[c] = m_p2[c];
          m_run[c]  = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_prev = m_db;
    m_db   = new_db;
    m_p2   = m_p1;
    m_p1   = SW;
  endtask

  task automatic compare_all();
    check("led_rel", led0, m_led[0]);
    check("db_rel",  db0,  m_db);
    check("evt_rel", evt0, m_evt[0]);
    check("led_prs", led1, m_led[1]);
    check("db_prs",  db1,  m_db);
    check("evt_prs", evt1, m_evt[1]);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic async_reset();
    #1 RST_N = 1'b0;
    #1;
    check("rst_led_rel", led0, 0);
    check("rst_db_rel",  db0,  0);
    check("rst_evt_rel", evt0, 0);
    check("rst_led_prs", led1, 0);
    model_reset();
    #1 RST_N = 1'b1;
  endtask

  int  edges;
  bit  found;

  initial begin
    RST_N = 1'b0; SW = '0; MODE = '0; CLR = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check("reset_led", {led1, led0}, 0);
    check("reset_db",  {db1, db0},   0);
    check("reset_evt", {evt1, evt0}, 0);
    RST_N = 1'b1;

    for (int i = 0; i < 20; i++) tick();

    // Press ch0: debounced level rises six edges after the pin change.
    SW[0] = 1'b1;
    edges = 0; found = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      tick();
      edges = k;
      if (db0[0]) found = 1;
    end
    check("press_latency", edges, 6);
    for (int k = 0; k < 4; k++) tick();

    // Release ch0: event and toggle land seven edges after the pin change.
    SW[0] = 1'b0;
    edges = 0; found = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      tick();
      edges = k;
      if (evt0[0]) found = 1;
    end
    check("release_evt_latency", edges, 7);
    check("release_led_toggled", led0[0], 1);
    tick();
    check("evt_one_cycle", evt0[0], 0);

    // Short glitches on ch1 never get through.
    for (int r = 0; r < 10; r++) begin
      SW[1] = 1'b1;
      for (int k = 0; k < 3; k++) tick();
      SW[1] = 1'b0;
      for (int k = 0; k < 2; k++) tick();
    end
    check("glitch_db",  db0[1],  0);
    check("glitch_led", led0[1], 0);

    // Reset during a partial count, then a full count is needed again.
    SW[2] = 1'b1;
    tick(); tick(); tick(); tick();
    async_reset();
    for (int k = 0; k < 5; k++) tick();
    check("post_reset_db_early", db0[2], 0);
    tick();
    check("post_reset_db_full", db0[2], 1);
    SW = '0;
    for (int k = 0; k < 10; k++) tick();

    // Randomised traffic: bursty switches, occasional mode flips, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(5) == 0) SW[c] = ~SW[c];
      if ($urandom_range(63) == 0) MODE[$urandom_range(NUM_CH - 1)] ^= 1'b1;
      CLR = ($urandom_range(31) == 0);
      if ($urandom_range(499) == 0) async_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
